// File: rtl/iob_cache_pkg.sv
// Shared definitions for the cache line-fill path.
//   fill_state_t   : line-fill FSM state encoding
//   calc_line2be_w : log2 of back-end beats per cache line
//   calc_cnt_w     : beat index / counter width (never below one bit)
package iob_cache_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_COMMIT  = 2'd2
  } fill_state_t;

  // Each beat carries be_data_w/fe_data_w front-end words, so the beat count
  // per line is the word count divided by that ratio.
  function automatic int calc_line2be_w(input int fe_data_w, input int be_data_w,
                                        input int word_offset_w);
    return word_offset_w - $clog2(be_data_w / fe_data_w);
  endfunction

  // A one-beat line still needs a one-bit index port.
  function automatic int calc_cnt_w(input int line2be_w);
    return (line2be_w > 0) ? line2be_w : 1;
  endfunction

endpackage

// File: rtl/iob_cache_line_fill_if.sv
// Back-end read channel carrying line-fill beats.
//   read_valid : beat strobe
//   read_addr  : beat index within the line
//   read_rdata : beat data
// Modports: master (memory side drives), slave (line-fill block receives).
interface iob_cache_line_fill_if #(
  parameter int BE_DATA_W = 32,
  parameter int ADDR_W    = 3
);
  logic                 read_valid;
  logic [ADDR_W-1:0]    read_addr;
  logic [BE_DATA_W-1:0] read_rdata;

  modport master (output read_valid, read_addr, read_rdata);
  modport slave  (input  read_valid, read_addr, read_rdata);
endinterface

// File: rtl/iob_cache_line_buf.sv
// Line buffer: one register per beat slot, each written on its own enable,
// whole line readable in parallel.
//   clk, rst_n : clock, asynchronous active-low reset
//   we         : write strobe
//   waddr      : beat slot to write
//   wdata      : beat data
//   line       : every slot concatenated, slot 0 in the LSBs
module iob_cache_line_buf #(
  parameter int BEAT_W  = 32,
  parameter int BEATS_N = 8,
  parameter int ADDR_W  = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      we,
  input  logic [ADDR_W-1:0]         waddr,
  input  logic [BEAT_W-1:0]         wdata,
  output logic [BEATS_N*BEAT_W-1:0] line
);

  logic [BEATS_N*BEAT_W-1:0] mem_r;

  // Slot storage; an index beyond the last slot writes nothing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_r <= '0;
    end else begin
      for (int b = 0; b < BEATS_N; b++) begin
        if (we && (waddr == ADDR_W'(b))) begin
          mem_r[b*BEAT_W +: BEAT_W] <= wdata;
        end
      end
    end
  end

  assign line = mem_r;

endmodule

// File: rtl/iob_cache_line_fill.sv
// Cache line fill: collects back-end beats into a line buffer, forwards the
// missed (critical) word as soon as its beat arrives, then commits the line.
//   clk_i, reset_n_i : clock, asynchronous active-low reset
//   fill_start_i     : opens a fill (IDLE only); req_word_i sampled with it
//   rd_bus           : back-end read channel (slave modport)
//   crit_valid_o     : one pulse per fill, cycle after the critical beat
//   crit_data_o      : critical word, held until the next fill
//   line_we_o        : one-cycle data-memory write strobe (COMMIT)
//   line_data_o      : committed line, word 0 in the LSBs
//   busy_o           : fill in progress (COLLECT/COMMIT)
//   err_o            : sticky out-of-sequence beat flag, cleared per fill
module iob_cache_line_fill
  import iob_cache_pkg::*;
#(
  parameter int FE_DATA_W     = 32,
  parameter int BE_DATA_W     = 32,
  parameter int WORD_OFFSET_W = 3
) (
  input  logic                                    clk_i,
  input  logic                                    reset_n_i,
  input  logic                                    fill_start_i,
  input  logic [WORD_OFFSET_W-1:0]                req_word_i,
  iob_cache_line_fill_if.slave                    rd_bus,
  output logic                                    crit_valid_o,
  output logic [FE_DATA_W-1:0]                    crit_data_o,
  output logic                                    line_we_o,
  output logic [(2**WORD_OFFSET_W)*FE_DATA_W-1:0] line_data_o,
  output logic                                    busy_o,
  output logic                                    err_o
);

  localparam int LINE2BE_W = calc_line2be_w(FE_DATA_W, BE_DATA_W, WORD_OFFSET_W);
  localparam int BEATS_N   = 2**LINE2BE_W;
  localparam int CNT_W     = calc_cnt_w(LINE2BE_W);
  localparam int RATIO_W   = WORD_OFFSET_W - LINE2BE_W;
  localparam int LINE_W    = BEATS_N * BE_DATA_W;

  fill_state_t              state_r;
  logic [CNT_W-1:0]         beat_cnt_r;
  logic [WORD_OFFSET_W-1:0] req_word_r;
  logic                     crit_done_r;

  logic                     buf_we_s;
  logic                     last_beat_s;
  logic                     crit_hit_s;
  logic [WORD_OFFSET_W-1:0] crit_beat_s;
  logic [WORD_OFFSET_W-1:0] crit_sub_s;
  logic [FE_DATA_W-1:0]     crit_word_s;
  logic [LINE_W-1:0]        buf_line_s;
  logic [LINE_W-1:0]        merged_line_s;

  // Beat decode: buffer write, last beat, critical beat and its word slice.
  always_comb begin
    buf_we_s    = (state_r == ST_COLLECT) && rd_bus.read_valid;
    last_beat_s = (beat_cnt_r == CNT_W'(BEATS_N - 1));
    crit_beat_s = req_word_r >> RATIO_W;
    crit_sub_s  = req_word_r & WORD_OFFSET_W'((32'd1 << RATIO_W) - 32'd1);
    // crit_done_r keeps the pulse unique if a beat index repeats.
    crit_hit_s  = !crit_done_r && (WORD_OFFSET_W'(rd_bus.read_addr) == crit_beat_s);
    crit_word_s = FE_DATA_W'(rd_bus.read_rdata >> (int'(crit_sub_s) * FE_DATA_W));
  end

  // The last beat is written into the buffer on the same edge that loads
  // line_data_o, so splice it in here to commit the complete line at once.
  always_comb begin
    merged_line_s = buf_line_s;
    for (int b = 0; b < BEATS_N; b++) begin
      if (rd_bus.read_addr == CNT_W'(b)) begin
        merged_line_s[b*BE_DATA_W +: BE_DATA_W] = rd_bus.read_rdata;
      end else begin
        merged_line_s[b*BE_DATA_W +: BE_DATA_W] = buf_line_s[b*BE_DATA_W +: BE_DATA_W];
      end
    end
  end

  iob_cache_line_buf #(
    .BEAT_W (BE_DATA_W),
    .BEATS_N(BEATS_N),
    .ADDR_W (CNT_W)
  ) u_line_buf (
    .clk  (clk_i),
    .rst_n(reset_n_i),
    .we   (buf_we_s),
    .waddr(rd_bus.read_addr),
    .wdata(rd_bus.read_rdata),
    .line (buf_line_s)
  );

  // Fill FSM with registered outputs.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r      <= ST_IDLE;
      beat_cnt_r   <= '0;
      req_word_r   <= '0;
      crit_done_r  <= 1'b0;
      crit_valid_o <= 1'b0;
      crit_data_o  <= '0;
      line_we_o    <= 1'b0;
      line_data_o  <= '0;
      busy_o       <= 1'b0;
      err_o        <= 1'b0;
    end else begin
      crit_valid_o <= 1'b0;
      line_we_o    <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (fill_start_i) begin
            state_r     <= ST_COLLECT;
            req_word_r  <= req_word_i;
            beat_cnt_r  <= '0;
            crit_done_r <= 1'b0;
            err_o       <= 1'b0;
            busy_o      <= 1'b1;
          end
        end
        ST_COLLECT: begin
          if (rd_bus.read_valid) begin
            if (rd_bus.read_addr != beat_cnt_r) begin
              err_o <= 1'b1;
            end
            if (crit_hit_s) begin
              crit_valid_o <= 1'b1;
              crit_data_o  <= crit_word_s;
              crit_done_r  <= 1'b1;
            end
            if (last_beat_s) begin
              beat_cnt_r  <= '0;
              state_r     <= ST_COMMIT;
              line_we_o   <= 1'b1;
              line_data_o <= merged_line_s;
            end else begin
              beat_cnt_r <= beat_cnt_r + CNT_W'(1'b1);
            end
          end
        end
        ST_COMMIT: begin
          state_r <= ST_IDLE;
          busy_o  <= 1'b0;
        end
        default: begin
          state_r <= ST_IDLE;
          busy_o  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iob_cache_line_fill.sv
// Self-checking bench for iob_cache_line_fill.
//   dut0: defaults (8 one-word beats), table of fills plus scoreboard
//   dut1: 64-bit beats, 4 beats per line
//   dut2: 64-bit beats, one-beat line
module tb_iob_cache_line_fill;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests_run = 0;
  int tests_failed = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    tests_run++;
    tests_failed++;
    $display("FAIL %s: unexpected pulse, expected none", name);
  endtask

  // ---------------- dut0: defaults ----------------
  logic         fs0 = 1'b0;
  logic [2:0]   rw0 = 3'd0;
  logic         crit_v0, we0, busy0, err0;
  logic [31:0]  crit_d0;
  logic [255:0] line0;
  iob_cache_line_fill_if #(.BE_DATA_W(32), .ADDR_W(3)) rd0 ();

  iob_cache_line_fill #(.FE_DATA_W(32), .BE_DATA_W(32), .WORD_OFFSET_W(3)) dut0 (
    .clk_i(clk), .reset_n_i(reset_n), .fill_start_i(fs0), .req_word_i(rw0), .rd_bus(rd0),
    .crit_valid_o(crit_v0), .crit_data_o(crit_d0), .line_we_o(we0), .line_data_o(line0),
    .busy_o(busy0), .err_o(err0));

  // ---------------- dut1: 64-bit beats ----------------
  logic         fs1 = 1'b0;
  logic [2:0]   rw1 = 3'd0;
  logic         crit_v1, we1, busy1, err1;
  logic [31:0]  crit_d1;
  logic [255:0] line1;
  iob_cache_line_fill_if #(.BE_DATA_W(64), .ADDR_W(2)) rd1 ();

  iob_cache_line_fill #(.FE_DATA_W(32), .BE_DATA_W(64), .WORD_OFFSET_W(3)) dut1 (
    .clk_i(clk), .reset_n_i(reset_n), .fill_start_i(fs1), .req_word_i(rw1), .rd_bus(rd1),
    .crit_valid_o(crit_v1), .crit_data_o(crit_d1), .line_we_o(we1), .line_data_o(line1),
    .busy_o(busy1), .err_o(err1));

  // ---------------- dut2: one-beat line ----------------
  logic         fs2 = 1'b0;
  logic [0:0]   rw2 = 1'b0;
  logic         crit_v2, we2, busy2, err2;
  logic [31:0]  crit_d2;
  logic [63:0]  line2;
  iob_cache_line_fill_if #(.BE_DATA_W(64), .ADDR_W(1)) rd2 ();

  iob_cache_line_fill #(.FE_DATA_W(32), .BE_DATA_W(64), .WORD_OFFSET_W(1)) dut2 (
    .clk_i(clk), .reset_n_i(reset_n), .fill_start_i(fs2), .req_word_i(rw2), .rd_bus(rd2),
    .crit_valid_o(crit_v2), .crit_data_o(crit_d2), .line_we_o(we2), .line_data_o(line2),
    .busy_o(busy2), .err_o(err2));

  // ---------------- dut0 scoreboard ----------------
  logic [31:0]  crit_q0[$];
  logic [255:0] line_q0[$];
  logic [255:0] prev_line0 = '0;
  logic         exp_err_commit0 = 1'b0;
  int crit_cnt0 = 0, we_cnt0 = 0, crit_cyc0 = 0, we_cyc0 = 0;
  int crit_cnt1 = 0, we_cnt1 = 0;

  always @(negedge clk) begin
    if (crit_v0) begin
      crit_cnt0 <= crit_cnt0 + 1;
      crit_cyc0 <= cyc;
      if (crit_q0.size() == 0) fail_now("crit_unexpected");
      else check("crit_data", {224'd0, crit_d0}, {224'd0, crit_q0.pop_front()});
    end
    if (we0) begin
      we_cnt0 <= we_cnt0 + 1;
      we_cyc0 <= cyc;
      check("busy_in_commit", {255'd0, busy0}, 256'd1);
      check("err_in_commit", {255'd0, err0}, {255'd0, exp_err_commit0});
      if (line_q0.size() == 0) fail_now("we_unexpected");
      else check("line_data", line0, line_q0.pop_front());
    end
    if (crit_v1) crit_cnt1 <= crit_cnt1 + 1;
    if (we1) we_cnt1 <= we_cnt1 + 1;
  end

  // kind 0: in order; kind 1: beats 2 and 3 swapped; kind 2: last beat repeats index 6
  task automatic fill0(input logic [2:0] rw, input logic [31:0] base, input int kind,
                       input logic [31:0] exp_crit, input bit exp_err, input bit inject);
    int order[8];
    logic [255:0] exp_line;
    int exp_crit_cyc, exp_we_cyc, c0, w0;
    bit e;
    exp_crit_cyc = -1;
    exp_we_cyc = -1;
    for (int i = 0; i < 8; i++) order[i] = i;
    if (kind == 1) begin order[2] = 3; order[3] = 2; end
    if (kind == 2) order[7] = 6;
    exp_line = prev_line0;
    for (int i = 0; i < 8; i++)
      if (!(kind == 2 && i == 7)) exp_line[32*i +: 32] = base + 32'(i);
    prev_line0 = exp_line;
    exp_err_commit0 = exp_err;
    crit_q0.push_back(exp_crit);
    line_q0.push_back(exp_line);
    c0 = crit_cnt0;
    w0 = we_cnt0;
    fs0 = 1'b1; rw0 = rw;
    @(posedge clk); #1;
    fs0 = 1'b0; rw0 = ~rw;
    check("busy_after_start", {255'd0, busy0}, 256'd1);
    check("err_cleared_on_start", {255'd0, err0}, 256'd0);
    for (int k = 0; k < 8; k++) begin
      rd0.read_valid = 1'b1;
      rd0.read_addr  = 3'(order[k]);
      rd0.read_rdata = base + 32'(order[k]);
      if (inject && k == 3) begin fs0 = 1'b1; rw0 = 3'd0; end
      @(posedge clk); #1;
      fs0 = 1'b0;
      if (order[k] == int'(rw) && exp_crit_cyc < 0) exp_crit_cyc = cyc;
      if (k == 7) exp_we_cyc = cyc;
      e = (kind == 1 && k >= 2) || (kind == 2 && k == 7);
      check("err_progress", {255'd0, err0}, {255'd0, e});
    end
    rd0.read_valid = 1'b0;
    @(posedge clk); #1;
    check("busy_after_commit", {255'd0, busy0}, 256'd0);
    check("crit_pulse_count", 256'(crit_cnt0 - c0), 256'd1);
    check("we_pulse_count", 256'(we_cnt0 - w0), 256'd1);
    check("crit_cycle", 256'(crit_cyc0), 256'(exp_crit_cyc));
    check("we_cycle", 256'(we_cyc0), 256'(exp_we_cyc));
    check("err_hold", {255'd0, err0}, {255'd0, exp_err});
    check("crit_hold", {224'd0, crit_d0}, {224'd0, exp_crit});
  endtask

  typedef struct {
    logic [2:0]  rw;
    logic [31:0] base;
    int          kind;
    logic [31:0] exp_crit;
    bit          exp_err;
  } vec_t;

  vec_t vecs[5];
  logic [255:0] exp_line1;
  int c1, w1;

  initial begin
    vecs[0] = '{3'd5, 32'h0000_0100, 0, 32'h0000_0105, 1'b0};
    vecs[1] = '{3'd7, 32'h0000_0200, 0, 32'h0000_0207, 1'b0};
    vecs[2] = '{3'd0, 32'h0000_0300, 0, 32'h0000_0300, 1'b0};
    vecs[3] = '{3'd2, 32'h0000_0400, 1, 32'h0000_0402, 1'b1};
    vecs[4] = '{3'd3, 32'hA5A5_0000, 1, 32'hA5A5_0003, 1'b1};

    rd0.read_valid = 1'b0; rd0.read_addr = 3'd0; rd0.read_rdata = 32'd0;
    rd1.read_valid = 1'b0; rd1.read_addr = 2'd0; rd1.read_rdata = 64'd0;
    rd2.read_valid = 1'b0; rd2.read_addr = 1'b0; rd2.read_rdata = 64'd0;

    // Reset state
    #12;
    check("rst_busy", {255'd0, busy0}, 256'd0);
    check("rst_err", {255'd0, err0}, 256'd0);
    check("rst_crit_valid", {255'd0, crit_v0}, 256'd0);
    check("rst_line_we", {255'd0, we0}, 256'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    check("line_zero_before_commit", line0, 256'd0);
    check("crit_data_zero", {224'd0, crit_d0}, 256'd0);

    // Table-driven fills
    for (int i = 0; i < 5; i++)
      fill0(vecs[i].rw, vecs[i].base, vecs[i].kind, vecs[i].exp_crit, vecs[i].exp_err, 1'b0);

    // Beats in IDLE must not touch the buffer: slot 7 is skipped by the next
    // fill, so it must still hold the previous fill's word.
    rd0.read_valid = 1'b1; rd0.read_addr = 3'd7; rd0.read_rdata = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rd0.read_valid = 1'b0;
    check("idle_beat_no_busy", {255'd0, busy0}, 256'd0);
    // fill_start during COLLECT is injected at beat 3 and must be ignored
    fill0(3'd5, 32'h0000_0600, 2, 32'h0000_0605, 1'b1, 1'b1);

    // Reset after 4 beats abandons the fill
    c1 = crit_cnt0;
    w1 = we_cnt0;
    fs0 = 1'b1; rw0 = 3'd6;
    @(posedge clk); #1;
    fs0 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      rd0.read_valid = 1'b1; rd0.read_addr = 3'(k); rd0.read_rdata = 32'h700 + 32'(k);
      @(posedge clk); #1;
    end
    rd0.read_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    check("rst_mid_busy", {255'd0, busy0}, 256'd0);
    check("rst_mid_line", line0, 256'd0);
    check("rst_mid_crit_data", {224'd0, crit_d0}, 256'd0);
    check("rst_mid_err", {255'd0, err0}, 256'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rst_mid_no_we", 256'(we_cnt0 - w1), 256'd0);
    check("rst_mid_no_crit", 256'(crit_cnt0 - c1), 256'd0);
    prev_line0 = '0;
    fill0(3'd1, 32'h0000_0800, 0, 32'h0000_0801, 1'b0, 1'b0);

    // dut1: 64-bit beats, req_word 3 is the upper half of beat 1
    c1 = crit_cnt1;
    w1 = we_cnt1;
    for (int i = 0; i < 8; i++) exp_line1[32*i +: 32] = 32'h2000_0000 + 32'(i);
    fs1 = 1'b1; rw1 = 3'd3;
    @(posedge clk); #1;
    fs1 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      rd1.read_valid = 1'b1;
      rd1.read_addr  = 2'(k);
      rd1.read_rdata = {32'h2000_0000 + 32'(2*k+1), 32'h2000_0000 + 32'(2*k)};
      @(posedge clk); #1;
      if (k == 1) begin
        check("w64_crit_valid", {255'd0, crit_v1}, 256'd1);
        check("w64_crit_data", {224'd0, crit_d1}, 256'h2000_0003);
      end
      if (k == 3) begin
        check("w64_line_we", {255'd0, we1}, 256'd1);
        check("w64_line_data", line1, exp_line1);
      end
    end
    rd1.read_valid = 1'b0;
    @(posedge clk); #1;
    check("w64_busy_done", {255'd0, busy1}, 256'd0);
    check("w64_crit_count", 256'(crit_cnt1 - c1), 256'd1);
    check("w64_we_count", 256'(we_cnt1 - w1), 256'd1);
    check("w64_err", {255'd0, err1}, 256'd0);

    // dut2: one-beat line completes on its first beat
    fs2 = 1'b1; rw2 = 1'b1;
    @(posedge clk); #1;
    fs2 = 1'b0;
    rd2.read_valid = 1'b1; rd2.read_addr = 1'b0; rd2.read_rdata = 64'hBBBB_BBBB_AAAA_AAAA;
    @(posedge clk); #1;
    rd2.read_valid = 1'b0;
    check("one_beat_we", {255'd0, we2}, 256'd1);
    check("one_beat_crit_valid", {255'd0, crit_v2}, 256'd1);
    check("one_beat_crit_data", {224'd0, crit_d2}, 256'hBBBB_BBBB);
    check("one_beat_line", {192'd0, line2}, {192'd0, 64'hBBBB_BBBB_AAAA_AAAA});
    check("one_beat_busy_commit", {255'd0, busy2}, 256'd1);
    @(posedge clk); #1;
    check("one_beat_busy_done", {255'd0, busy2}, 256'd0);
    check("one_beat_we_done", {255'd0, we2}, 256'd0);
    check("one_beat_err", {255'd0, err2}, 256'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
